// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg: shared types and constants for the USB command decoder.
//   state_e   - frame parser states
//   SYNC_DEF  - default frame start byte
//   FRAME_LEN - bytes per frame including SYNC; 7 when USB_CMD_CSUM_EN
//               is defined (trailing XOR checksum byte), otherwise 6.
package usb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_DEF = 8'hA5;

`ifdef USB_CMD_CSUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

endpackage

// File: rtl/usb_cmd_regfile.sv
// usb_cmd_regfile: NREG x 32-bit control register bank.
//   clk, rst        - clock, synchronous active-high reset (clears all)
//   we, addr, data  - single write port, written on the rising edge
//   regs            - flattened bank, regs[32*i +: 32] = register i
module usb_cmd_regfile #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       data,
    output logic [NREG*32-1:0] regs
);

    logic [NREG-1:0][31:0] mem;

    // One enable per register so a non-power-of-two NREG never indexes
    // past the end of the bank.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst)
                mem[i] <= '0;
            else if (we && addr == AW'(i))
                mem[i] <= data;
        end
    end

    assign regs = mem;

endmodule

// File: rtl/usb_cmd_decoder.sv
// usb_cmd_decoder: parses the host byte stream into register-write frames
//   SYNC, ADDR, D0, D1, D2, D3 [, CSUM]   (data little-endian, D0 = bits 7:0)
// Build option: define USB_CMD_CSUM_EN to require a trailing checksum byte
// equal to ADDR^D0^D1^D2^D3; undefined, the frame ends on D3.
// Ports:
//   IFCLK     - USB interface clock, rising edge
//   RST       - synchronous active-high reset
//   DOWNWR    - byte strobe, DOWNDATA valid when high
//   DOWNDATA  - host byte
//   REGS      - flattened register bank, REGS[32*i +: 32] = register i
//   REG_WE    - one-cycle pulse after a register write
//   REG_ADDR  - address of the last write
//   REG_DATA  - data of the last write
//   ERR_CNT   - saturating count of rejected / timed-out frames
module usb_cmd_decoder
    import usb_cmd_pkg::*;
#(
    parameter int         NREG    = 8,
    parameter int         AW      = 3,
    parameter logic [7:0] SYNC    = SYNC_DEF,
    parameter int         TIMEOUT = 1024
) (
    input  logic               IFCLK,
    input  logic               RST,
    input  logic               DOWNWR,
    input  logic [7:0]         DOWNDATA,
    output logic [NREG*32-1:0] REGS,
    output logic               REG_WE,
    output logic [AW-1:0]      REG_ADDR,
    output logic [31:0]        REG_DATA,
    output logic [7:0]         ERR_CNT
);

    localparam int TW = $clog2(TIMEOUT);

    state_e        state;
    logic [7:0]    addr_q;
    logic [1:0]    idx;
    logic [TW-1:0] to_cnt;

    logic          addr_ok, frame_ok, last_byte, commit, reject, to_hit;
    logic [31:0]   wr_data;

    assign addr_ok = ((addr_q >> AW) == 8'd0) && (32'(addr_q[AW-1:0]) < NREG);

`ifdef USB_CMD_CSUM_EN
    logic [31:0] data_sr;
    logic [7:0]  csum_q;
    assign last_byte = DOWNWR && state == ST_CSUM;
    assign frame_ok  = addr_ok && (DOWNDATA == csum_q);
    assign wr_data   = data_sr;
`else
    // Only D0..D2 are held; D3 is taken straight off the bus at commit.
    logic [23:0] data_sr;
    assign last_byte = DOWNWR && state == ST_DATA && idx == 2'd3;
    assign frame_ok  = addr_ok;
    assign wr_data   = {DOWNDATA, data_sr};
`endif

    assign commit = last_byte && frame_ok;
    assign reject = last_byte && !frame_ok;
    // A byte in the expiry cycle wins, hence the !DOWNWR term.
    assign to_hit = state != ST_HUNT && !DOWNWR && to_cnt == TW'(TIMEOUT - 1);

    always_ff @(posedge IFCLK) begin
        if (RST) begin
            state    <= ST_HUNT;
            addr_q   <= '0;
            idx      <= '0;
            to_cnt   <= '0;
            data_sr  <= '0;
`ifdef USB_CMD_CSUM_EN
            csum_q   <= '0;
`endif
            REG_WE   <= 1'b0;
            REG_ADDR <= '0;
            REG_DATA <= '0;
            ERR_CNT  <= '0;
        end else begin
            REG_WE <= commit;
            if (commit) begin
                REG_ADDR <= addr_q[AW-1:0];
                REG_DATA <= wr_data;
            end
            if ((reject || to_hit) && ERR_CNT != 8'hFF)
                ERR_CNT <= ERR_CNT + 8'd1;

            if (state == ST_HUNT || DOWNWR || to_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            case (state)
                ST_HUNT: if (DOWNWR && DOWNDATA == SYNC) state <= ST_ADDR;
                ST_ADDR: if (DOWNWR) begin
                    addr_q <= DOWNDATA;
                    idx    <= 2'd0;
`ifdef USB_CMD_CSUM_EN
                    csum_q <= DOWNDATA;
`endif
                    state  <= ST_DATA;
                end
                ST_DATA: if (DOWNWR) begin
`ifdef USB_CMD_CSUM_EN
                    data_sr <= {DOWNDATA, data_sr[31:8]};
                    csum_q  <= csum_q ^ DOWNDATA;
                    if (idx == 2'd3) state <= ST_CSUM;
`else
                    data_sr <= {DOWNDATA, data_sr[23:8]};
                    if (idx == 2'd3) state <= ST_HUNT;
`endif
                    idx <= idx + 2'd1;
                end
                ST_CSUM: if (DOWNWR) state <= ST_HUNT;
                default: state <= ST_HUNT;
            endcase

            if (to_hit)
                state <= ST_HUNT;
        end
    end

    usb_cmd_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
        .clk  (IFCLK),
        .rst  (RST),
        .we   (commit),
        .addr (addr_q[AW-1:0]),
        .data (wr_data),
        .regs (REGS)
    );

endmodule

// File: tb/tb_usb_cmd_decoder.sv
module tb_usb_cmd_decoder;

    logic         IFCLK = 1'b0;
    logic         RST = 1'b1;
    logic         DOWNWR = 1'b0;
    logic [7:0]   DOWNDATA = 8'h00;
    logic [255:0] REGS;
    logic         REG_WE;
    logic [2:0]   REG_ADDR;
    logic [31:0]  REG_DATA;
    logic [7:0]   ERR_CNT;

    int checks = 0;
    int failures = 0;

    logic [7:0][31:0] mdl;

    usb_cmd_decoder dut (
        .IFCLK    (IFCLK),
        .RST      (RST),
        .DOWNWR   (DOWNWR),
        .DOWNDATA (DOWNDATA),
        .REGS     (REGS),
        .REG_WE   (REG_WE),
        .REG_ADDR (REG_ADDR),
        .REG_DATA (REG_DATA),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 IFCLK = ~IFCLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: present a byte (or idle), consume it on the edge, return #1 later.
    task automatic cyc(input logic wr, input logic [7:0] d);
        DOWNWR = wr;
        DOWNDATA = d;
        @(posedge IFCLK);
        #1;
        DOWNWR = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic bad_csum);
        logic [7:0] cs;
        cs = a ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
        if (bad_csum) cs = ~cs;
        cyc(1'b1, 8'hA5);
        cyc(1'b1, a);
        cyc(1'b1, d[7:0]);
        cyc(1'b1, d[15:8]);
        cyc(1'b1, d[23:16]);
        cyc(1'b1, d[31:24]);
`ifdef USB_CMD_CSUM_EN
        cyc(1'b1, cs);
`endif
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        we;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'h02, 32'h12345678, 1'b1, 8'd0};
        vecs[1] = '{8'h08, 32'h11111111, 1'b0, 8'd1};
        vecs[2] = '{8'h05, 32'hA5A5A5A5, 1'b1, 8'd1};
        vecs[3] = '{8'h80, 32'h22222222, 1'b0, 8'd2};
        vecs[4] = '{8'h07, 32'h00000001, 1'b1, 8'd2};
        vecs[5] = '{8'h02, 32'h0000A500, 1'b1, 8'd2};
        mdl = '0;

        // reset state
        idle(3);
        RST = 1'b0;
        idle(1);
        chk("reset_regs", REGS, 256'd0);
        chk("reset_we", REG_WE, 0);
        chk("reset_addr", REG_ADDR, 0);
        chk("reset_data", REG_DATA, 0);
        chk("reset_err", ERR_CNT, 0);

        // junk bytes in HUNT are dropped without counting
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h5A);
        chk("junk_err", ERR_CNT, 0);

        // table-driven frames
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].addr, vecs[v].data, 1'b0);
            if (vecs[v].we) mdl[vecs[v].addr[2:0]] = vecs[v].data;
            chk($sformatf("v%0d_we", v), REG_WE, vecs[v].we);
            if (vecs[v].we) begin
                chk($sformatf("v%0d_addr", v), REG_ADDR, vecs[v].addr[2:0]);
                chk($sformatf("v%0d_data", v), REG_DATA, vecs[v].data);
            end
            chk($sformatf("v%0d_regs", v), REGS, mdl);
            chk($sformatf("v%0d_err", v), ERR_CNT, vecs[v].err);
            idle(1);
            chk($sformatf("v%0d_we_drop", v), REG_WE, 0);
        end

        // timeout: 11 22 A5 01 then 1024 idle cycles aborts
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h01);
        idle(1024);
        chk("to_err", ERR_CNT, 3);
        chk("to_regs", REGS, mdl);
        send_frame(8'h01, 32'hCAFEF00D, 1'b0);
        mdl[1] = 32'hCAFEF00D;
        chk("to_next_we", REG_WE, 1);
        chk("to_next_regs", REGS, mdl);
        chk("to_next_err", ERR_CNT, 3);

        // byte in the expiry cycle wins: 1023 idle cycles then the next byte
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h04);
        idle(1023);
        cyc(1'b1, 8'h44);
        cyc(1'b1, 8'h33);
        cyc(1'b1, 8'h22);
        cyc(1'b1, 8'h11);
`ifdef USB_CMD_CSUM_EN
        cyc(1'b1, 8'h04 ^ 8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11);
`endif
        mdl[4] = 32'h11223344;
        chk("edge_we", REG_WE, 1);
        chk("edge_regs", REGS, mdl);
        chk("edge_err", ERR_CNT, 3);

        // back-to-back frames, zero idle
        send_frame(8'h00, 32'hDEADBEEF, 1'b0);
        chk("b2b0_we", REG_WE, 1);
        chk("b2b0_addr", REG_ADDR, 0);
        send_frame(8'h07, 32'h00000001, 1'b0);
        mdl[0] = 32'hDEADBEEF;
        mdl[7] = 32'h00000001;
        chk("b2b1_we", REG_WE, 1);
        chk("b2b1_addr", REG_ADDR, 7);
        chk("b2b_regs", REGS, mdl);

`ifdef USB_CMD_CSUM_EN
        send_frame(8'h02, 32'h12345678, 1'b1);
        chk("csum_bad_we", REG_WE, 0);
        chk("csum_bad_regs", REGS, mdl);
        chk("csum_bad_err", ERR_CNT, 4);
`endif

        // reset mid-frame after D1
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h03);
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        mdl = '0;
        chk("rst_mid_regs", REGS, 256'd0);
        chk("rst_mid_err", ERR_CNT, 0);
        chk("rst_mid_we", REG_WE, 0);
        send_frame(8'h03, 32'h0BADF00D, 1'b0);
        mdl[3] = 32'h0BADF00D;
        chk("rst_new_regs", REGS, mdl);
        chk("rst_new_err", ERR_CNT, 0);

        // saturation: 300 rejected frames
        for (int i = 0; i < 300; i++) begin
`ifdef USB_CMD_CSUM_EN
            send_frame(8'h06, 32'h55AA55AA, 1'b1);
`else
            send_frame(8'h09, 32'h55AA55AA, 1'b0);
`endif
            if (i == 254) chk("sat_255", ERR_CNT, 8'hFF);
        end
        chk("sat_err", ERR_CNT, 8'hFF);
        chk("sat_regs", REGS, mdl);
        idle(1);
        chk("sat_we", REG_WE, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
